// File: rtl/warp_barrier_ctrl_pkg.sv
// Shared types and constants for the warp barrier controller.
//   slot_state_e : per-slot barrier FSM state (IDLE = no arrivals, WAIT = collecting)
//   PERF_W       : width of the optional performance counters (BARRIER_PERF_EN)
package warp_barrier_ctrl_pkg;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_WAIT = 1'b1
    } slot_state_e;

    localparam int PERF_W = 44;

endpackage

// File: rtl/warp_barrier_slot.sv
// One barrier slot: arrival counter, latched size, wait mask and IDLE/WAIT FSM.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   arrive              accepted, error-free arrival addressed to this slot
//   size_m1, wid        arriving request's size-minus-one and warp ID
//   size_mismatch       slot is waiting and size_m1 differs from the latched size
//   release_hit         this arrival completes the barrier (combinational)
//   wait_mask           warps currently parked on this slot
//   mask_next           wait_mask value after this cycle's arrival
module warp_barrier_slot
    import warp_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arrive,
    input  logic [NW_BITS-1:0]   size_m1,
    input  logic [NW_BITS-1:0]   wid,
    output logic                 size_mismatch,
    output logic                 release_hit,
    output logic [NUM_WARPS-1:0] wait_mask,
    output logic [NUM_WARPS-1:0] mask_next
);

    typedef struct packed {
        logic                 active;
        logic [NW_BITS-1:0]   count;
        logic [NW_BITS-1:0]   size_m1;
        logic [NUM_WARPS-1:0] wait_mask;
    } barrier_slot_t;

    slot_state_e          state;
    barrier_slot_t        slot;
    logic [NUM_WARPS-1:0] wid_bit;

    assign wid_bit       = NUM_WARPS'(1) << wid;
    assign wait_mask     = slot.wait_mask;
    assign size_mismatch = slot.active && (size_m1 != slot.size_m1);

    // A single-warp barrier completes on its first (and only) arrival.
    assign release_hit = arrive && ((state == SLOT_IDLE) ? (size_m1 == '0)
                                                         : (slot.count == slot.size_m1));

    always_comb begin
        mask_next = slot.wait_mask;
        if (arrive)
            mask_next = release_hit ? '0 : (slot.wait_mask | wid_bit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLOT_IDLE;
            slot  <= '0;
        end else if (arrive) begin
            if (state == SLOT_IDLE) begin
                if (size_m1 != '0) begin
                    state          <= SLOT_WAIT;
                    slot.active    <= 1'b1;
                    slot.count     <= NW_BITS'(1);
                    slot.size_m1   <= size_m1;
                    slot.wait_mask <= wid_bit;
                end
            end else begin
                if (slot.count == slot.size_m1) begin
                    state <= SLOT_IDLE;
                    slot  <= '0;
                end else begin
                    slot.count     <= slot.count + NW_BITS'(1);
                    slot.wait_mask <= slot.wait_mask | wid_bit;
                end
            end
        end
    end

endmodule

// File: rtl/warp_barrier_ctrl.sv
// Per-core barrier scheduler. Counts warp arrivals per barrier ID, holds
// arriving warps in stall_mask, and emits a one-cycle release pulse with the
// released warp mask when the last participant arrives.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   bar_valid/bar_id/bar_size_m1/bar_wid   barrier request from execute unit
//   bar_ready                         1 every cycle after reset
//   stall_mask                        warps blocked at any barrier (registered)
//   release_valid/release_id/release_mask  registered release bundle
//   bar_err                           sticky protocol-error flag
// Optional (macro BARRIER_PERF_EN):
//   perf_bar_stalls                   saturating sum of popcount(stall_mask)
//   perf_bar_releases                 number of release pulses
module warp_barrier_ctrl
    import warp_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bar_valid,
    input  logic [NB_BITS-1:0]   bar_id,
    input  logic [NW_BITS-1:0]   bar_size_m1,
    input  logic [NW_BITS-1:0]   bar_wid,
    output logic                 bar_ready,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_mask,
`ifdef BARRIER_PERF_EN
    output logic [PERF_W-1:0]    perf_bar_stalls,
    output logic [PERF_W-1:0]    perf_bar_releases,
`endif
    output logic                 bar_err
);

    localparam int BAR_RELEASE_BITS = 1 + NB_BITS + NUM_WARPS;

    logic [NUM_BARRIERS-1:0]                slot_arrive;
    logic [NUM_BARRIERS-1:0]                slot_mismatch;
    logic [NUM_BARRIERS-1:0]                slot_release;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] slot_mask;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] slot_mask_next;

    logic                        accept, dup, size_err, proto_err, any_release;
    logic [NUM_WARPS-1:0]        wid_bit, all_wait, sel_mask, stall_next;
    logic [BAR_RELEASE_BITS-1:0] rel_next, rel_q;

    assign accept  = bar_valid && bar_ready;
    assign wid_bit = NUM_WARPS'(1) << bar_wid;

    always_comb begin
        all_wait   = '0;
        stall_next = '0;
        sel_mask   = '0;
        size_err   = 1'b0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            all_wait   = all_wait | slot_mask[i];
            stall_next = stall_next | slot_mask_next[i];
            if (bar_id == NB_BITS'(i)) begin
                sel_mask = slot_mask[i];
                size_err = slot_mismatch[i];
            end
        end
    end

    // A warp may wait on only one barrier at a time; a re-arrival from a
    // parked warp is dropped, as is a size disagreement with a waiting slot.
    assign dup       = |(all_wait & wid_bit);
    assign proto_err = accept && (dup || size_err);

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        assign slot_arrive[g] = accept && !proto_err && (bar_id == NB_BITS'(g));

        warp_barrier_slot #(
            .NUM_WARPS (NUM_WARPS),
            .NW_BITS   (NW_BITS)
        ) u_slot (
            .clk           (clk),
            .reset_n       (reset_n),
            .arrive        (slot_arrive[g]),
            .size_m1       (bar_size_m1),
            .wid           (bar_wid),
            .size_mismatch (slot_mismatch[g]),
            .release_hit   (slot_release[g]),
            .wait_mask     (slot_mask[g]),
            .mask_next     (slot_mask_next[g])
        );
    end

    // Only one arrival is accepted per cycle, so at most one slot releases.
    assign any_release = |slot_release;
    assign rel_next    = {any_release,
                          any_release ? bar_id : NB_BITS'(0),
                          any_release ? (sel_mask | wid_bit) : NUM_WARPS'(0)};

    assign {release_valid, release_id, release_mask} = rel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_ready  <= 1'b0;
            bar_err    <= 1'b0;
            stall_mask <= '0;
            rel_q      <= '0;
        end else begin
            bar_ready  <= 1'b1;
            bar_err    <= bar_err | proto_err;
            stall_mask <= stall_next;
            rel_q      <= rel_next;
        end
    end

`ifdef BARRIER_PERF_EN
    localparam int PC_W = NW_BITS + 1;

    logic [PC_W-1:0]   stall_pop;
    logic [PERF_W:0]   stalls_sum;

    always_comb begin
        stall_pop = '0;
        for (int i = 0; i < NUM_WARPS; i++)
            stall_pop = stall_pop + PC_W'(stall_mask[i]);
    end

    // One extra carry bit detects overflow; the counter then pins at all-ones.
    assign stalls_sum = {1'b0, perf_bar_stalls} + (PERF_W + 1)'(stall_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_bar_stalls   <= '0;
            perf_bar_releases <= '0;
        end else begin
            perf_bar_stalls   <= stalls_sum[PERF_W] ? '1 : stalls_sum[PERF_W-1:0];
            perf_bar_releases <= perf_bar_releases + PERF_W'(release_valid);
        end
    end
`endif

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
module tb_warp_barrier_ctrl;

    localparam int NW  = 4;
    localparam int NB  = 4;
    localparam int NWB = 2;
    localparam int NBB = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           bar_valid = 1'b0;
    logic [NBB-1:0] bar_id = '0;
    logic [NWB-1:0] bar_size_m1 = '0;
    logic [NWB-1:0] bar_wid = '0;
    logic           bar_ready;
    logic [NW-1:0]  stall_mask;
    logic           release_valid;
    logic [NBB-1:0] release_id;
    logic [NW-1:0]  release_mask;
    logic           bar_err;
`ifdef BARRIER_PERF_EN
    logic [43:0]    perf_bar_stalls;
    logic [43:0]    perf_bar_releases;
`endif

    always #5 clk = ~clk;

    warp_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bar_valid         (bar_valid),
        .bar_id            (bar_id),
        .bar_size_m1       (bar_size_m1),
        .bar_wid           (bar_wid),
        .bar_ready         (bar_ready),
        .stall_mask        (stall_mask),
        .release_valid     (release_valid),
        .release_id        (release_id),
        .release_mask      (release_mask),
`ifdef BARRIER_PERF_EN
        .perf_bar_stalls   (perf_bar_stalls),
        .perf_bar_releases (perf_bar_releases),
`endif
        .bar_err           (bar_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NBB-1:0] id;
        logic [NW-1:0]  mask;
    } rel_t;

    rel_t exp_q[$];

    // Reference model of barrier bookkeeping
    bit [NB-1:0]   m_act;
    int            m_cnt [NB];
    int            m_size[NB];
    logic [NW-1:0] m_mask[NB];
    logic          m_err;

    function automatic logic [NW-1:0] model_stall();
        logic [NW-1:0] s = '0;
        for (int i = 0; i < NB; i++) s = s | m_mask[i];
        return s;
    endfunction

    task automatic model_reset();
        m_act = '0;
        m_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_cnt[i] = 0; m_size[i] = 0; m_mask[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input int id, input int sz, input int wid);
        logic [NW-1:0] wb = NW'(1) << wid;
        logic [NW-1:0] st = model_stall();
        rel_t r;
        if ((st & wb) != '0 || (m_act[id] && m_size[id] != sz)) begin
            m_err = 1'b1;
        end else if (!m_act[id]) begin
            if (sz == 0) begin
                r.id = NBB'(id); r.mask = wb; exp_q.push_back(r);
            end else begin
                m_act[id] = 1'b1; m_cnt[id] = 1; m_size[id] = sz; m_mask[id] = wb;
            end
        end else if (m_cnt[id] == sz) begin
            r.id = NBB'(id); r.mask = m_mask[id] | wb; exp_q.push_back(r);
            m_act[id] = 1'b0; m_cnt[id] = 0; m_mask[id] = '0;
        end else begin
            m_cnt[id] = m_cnt[id] + 1;
            m_mask[id] = m_mask[id] | wb;
        end
    endtask

    // Called #1 after a rising edge: pops the scoreboard on release, checks stall/err.
    task automatic check_cycle(input string tag);
        rel_t e;
        n_checks++;
        if (release_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s release: got unexpected id=%0d mask=%b, required none", tag, release_id, release_mask);
            end else begin
                e = exp_q.pop_front();
                if (release_id !== e.id || release_mask !== e.mask) begin
                    n_fail++;
                    $display("FAIL %s release: got id=%0d mask=%b, required id=%0d mask=%b",
                             tag, release_id, release_mask, e.id, e.mask);
                end
            end
        end else if (release_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s release: got release_valid=%b, required %0d", tag, release_valid, exp_q.size() != 0);
            exp_q.delete();
        end
        n_checks++;
        if (stall_mask !== model_stall()) begin
            n_fail++;
            $display("FAIL %s stall_mask: got %b, required %b", tag, stall_mask, model_stall());
        end
        n_checks++;
        if (bar_err !== m_err) begin
            n_fail++;
            $display("FAIL %s bar_err: got %b, required %b", tag, bar_err, m_err);
        end
    endtask

    task automatic arrive(input int id, input int sz, input int wid, input string tag);
        @(negedge clk);
        bar_valid = 1'b1; bar_id = NBB'(id); bar_size_m1 = NWB'(sz); bar_wid = NWB'(wid);
        model_step(id, sz, wid);
        @(posedge clk); #1;
        check_cycle(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            bar_valid = 1'b0;
            @(posedge clk); #1;
            check_cycle(tag);
        end
    endtask

    task automatic check_stall_lit(input logic [NW-1:0] req, input string tag);
        n_checks++;
        if (stall_mask !== req) begin
            n_fail++;
            $display("FAIL %s stall literal: got %b, required %b", tag, stall_mask, req);
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({bar_ready, stall_mask, release_valid, release_id, release_mask, bar_err} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy=%b stall=%b rv=%b rid=%0d rm=%b err=%b, required all 0",
                     bar_ready, stall_mask, release_valid, release_id, release_mask, bar_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bar_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready_before_edge: got %b, required 0", bar_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_after_edge: got %b, required 1", bar_ready);
        end
        check_cycle("reset");
    endtask

    task automatic test_full_barrier();
        arrive(1, 3, 0, "full_w0"); check_stall_lit(4'b0001, "full_w0");
        arrive(1, 3, 1, "full_w1"); check_stall_lit(4'b0011, "full_w1");
        arrive(1, 3, 2, "full_w2"); check_stall_lit(4'b0111, "full_w2");
        arrive(1, 3, 3, "full_w3"); check_stall_lit(4'b0000, "full_w3");
        n_checks++;
        if (release_valid !== 1'b1 || release_id !== 2'd1 || release_mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL full release literal: got rv=%b id=%0d mask=%b, required rv=1 id=1 mask=1111",
                     release_valid, release_id, release_mask);
        end
        idle(1, "full_deassert");
    endtask

    task automatic test_single_warp();
        arrive(0, 0, 2, "single");
        check_stall_lit(4'b0000, "single");
        n_checks++;
        if (release_valid !== 1'b1 || release_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL single release literal: got rv=%b mask=%b, required rv=1 mask=0100", release_valid, release_mask);
        end
        idle(1, "single_deassert");
    endtask

    task automatic test_interleaved();
        arrive(0, 1, 0, "inter_a0");
        arrive(2, 1, 1, "inter_b1");
        check_stall_lit(4'b0011, "inter_b1");
        arrive(2, 1, 3, "inter_b3");
        check_stall_lit(4'b0001, "inter_b3");
        arrive(0, 1, 2, "inter_a2");
        check_stall_lit(4'b0000, "inter_a2");
        idle(1, "inter_idle");
    endtask

    task automatic test_back_to_back();
        arrive(3, 1, 0, "b2b_w0");
        arrive(3, 1, 1, "b2b_w1");
        arrive(3, 0, 2, "b2b_w2");
        idle(2, "b2b_idle");
    endtask

    task automatic test_errors();
        arrive(0, 2, 0, "err_first");
        arrive(0, 1, 1, "err_size");
        check_stall_lit(4'b0001, "err_size");
        arrive(3, 0, 0, "err_dup");
        check_stall_lit(4'b0001, "err_dup");
        arrive(0, 2, 1, "err_recover1");
        arrive(0, 2, 2, "err_recover2");
        idle(1, "err_idle");
    endtask

    task automatic test_reset_mid_wait();
        arrive(1, 1, 0, "mid_w0");
        @(negedge clk);
        bar_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bar_ready, stall_mask, release_valid, bar_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: got rdy=%b stall=%b rv=%b err=%b, required all 0",
                     bar_ready, stall_mask, release_valid, bar_err);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_cycle("mid_after");
        arrive(1, 1, 1, "mid_w1");
        arrive(1, 1, 0, "mid_w0b");
        idle(1, "mid_idle");
    endtask

`ifdef BARRIER_PERF_EN
    task automatic test_perf();
        logic [43:0] s0, r0;
        arrive(1, 2, 0, "perf_w0");
        arrive(1, 2, 1, "perf_w1");
        s0 = perf_bar_stalls;
        idle(5, "perf_hold");
        n_checks++;
        if (perf_bar_stalls - s0 !== 44'd10) begin
            n_fail++;
            $display("FAIL perf stalls: got delta %0d, required 10", perf_bar_stalls - s0);
        end
        r0 = perf_bar_releases;
        arrive(1, 2, 2, "perf_rel");
        idle(1, "perf_idle");
        n_checks++;
        if (perf_bar_releases - r0 !== 44'd1) begin
            n_fail++;
            $display("FAIL perf releases: got delta %0d, required 1", perf_bar_releases - r0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_barrier();
        test_single_warp();
        test_interleaved();
        test_back_to_back();
        test_errors();
        test_reset_mid_wait();
`ifdef BARRIER_PERF_EN
        test_perf();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover releases: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
